// File: rtl/serial_subtractor_if.sv
// serial_subtractor_if: start/done handshake, operands and result/flag bus of the serial subtractor
interface serial_subtractor_if #(parameter int WIDTH = 32);
  logic             start;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] D;
  logic             Bout;
  logic             V;
  logic             Z;
  modport master (output start, A, B, input busy, done, D, Bout, V, Z);
  modport slave  (input start, A, B, output busy, done, D, Bout, V, Z);
endinterface

// File: rtl/serial_subtractor.sv
// serial_subtractor: bit-serial D = A + ~B + 1, one bit per clock, with borrow/overflow/zero flags
module serial_subtractor #(
  parameter int WIDTH = 32
) (
  input logic               clk,
  input logic               rst_n,
  serial_subtractor_if.slave bus
);
  localparam int CW = $clog2(WIDTH);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, sh_q, sh_d, d_q, d_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             carry_q, carry_d, am_q, am_d, bm_q, bm_d;
  logic             bout_q, bout_d, v_q, v_d, z_q, z_d, busy_q, busy_d, done_q, done_d;
  logic             nb, s, cy;
  logic [WIDTH-1:0] dn;
  assign nb = ~b_q[0];
  assign s  = a_q[0] ^ nb ^ carry_q;
  assign cy = (a_q[0] & nb) | (a_q[0] & carry_q) | (nb & carry_q);
  assign dn = {s, sh_q[WIDTH-1:1]};
  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.D    = d_q;
  assign bus.Bout = bout_q;
  assign bus.V    = v_q;
  assign bus.Z    = z_q;
  // next state: capture in IDLE, shift one full-adder bit per RUN cycle, publish result on the last bit
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    sh_d    = sh_q;
    d_d     = d_q;
    cnt_d   = cnt_q;
    carry_d = carry_q;
    am_d    = am_q;
    bm_d    = bm_q;
    bout_d  = bout_q;
    v_d     = v_q;
    z_d     = z_q;
    busy_d  = busy_q;
    done_d  = done_q;
    case (state_q)
      IDLE: if (bus.start) begin
        a_d     = bus.A;
        b_d     = bus.B;
        am_d    = bus.A[WIDTH-1];
        bm_d    = bus.B[WIDTH-1];
        carry_d = 1'b1;
        cnt_d   = '0;
        busy_d  = 1'b1;
        state_d = RUN;
      end
      RUN: begin
        a_d     = a_q >> 1;
        b_d     = b_q >> 1;
        sh_d    = dn;
        carry_d = cy;
        cnt_d   = cnt_q + 1'b1;
        if (cnt_q == CW'(WIDTH - 1)) begin
          d_d     = dn;
          bout_d  = ~cy;
          v_d     = (am_q != bm_q) & (dn[WIDTH-1] != am_q);
          z_d     = dn == '0;
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = DONE;
        end
      end
      DONE: begin
        done_d  = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
  // state register with synchronous active-low reset that aborts any operation in flight
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      sh_q    <= '0;
      d_q     <= '0;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      am_q    <= 1'b0;
      bm_q    <= 1'b0;
      bout_q  <= 1'b0;
      v_q     <= 1'b0;
      z_q     <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sh_q    <= sh_d;
      d_q     <= d_d;
      cnt_q   <= cnt_d;
      carry_q <= carry_d;
      am_q    <= am_d;
      bm_q    <= bm_d;
      bout_q  <= bout_d;
      v_q     <= v_d;
      z_q     <= z_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end
endmodule

// File: tb/tb_serial_subtractor.sv
// tb_serial_subtractor: directed checks of the serial subtractor result, flags, latency and handshake
module tb_serial_subtractor;
  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   n, bc, t1, t2, pulses;
  serial_subtractor_if #(.WIDTH(32)) bus ();
  serial_subtractor #(.WIDTH(32)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic wait_done(output int edges, output int busy_cnt);
    edges = 0;
    busy_cnt = 0;
    do begin
      @(posedge clk);
      #1;
      edges++;
      if (bus.busy) busy_cnt++;
    end while (!bus.done && edges < 100);
  endtask
  task automatic op(input logic [31:0] a, input logic [31:0] b, input logic [31:0] ed,
                    input logic eb, input logic ev, input logic ez, input string tag);
    int e, k;
    @(negedge clk);
    bus.A = a;
    bus.B = b;
    bus.start = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    chk({tag, "_busy"}, bus.busy, 1);
    wait_done(e, k);
    chk({tag, "_latency"}, e + 1, 33);
    chk({tag, "_busy_cycles"}, k + 1, 32);
    chk({tag, "_D"}, bus.D, ed);
    chk({tag, "_Bout"}, bus.Bout, eb);
    chk({tag, "_V"}, bus.V, ev);
    chk({tag, "_Z"}, bus.Z, ez);
    @(posedge clk);
    #1;
    chk({tag, "_done_width"}, bus.done, 0);
  endtask
  initial begin
    rst_n = 1'b0;
    bus.start = 1'b0;
    bus.A = '0;
    bus.B = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", bus.busy, 0);
    chk("rst_done", bus.done, 0);
    chk("rst_D", bus.D, 0);
    chk("rst_Bout", bus.Bout, 0);
    chk("rst_V", bus.V, 0);
    chk("rst_Z", bus.Z, 0);
    @(negedge clk);
    rst_n = 1'b1;
    op(32'd5, 32'd3, 32'h0000_0002, 1'b0, 1'b0, 1'b0, "5m3");
    op(32'd3, 32'd5, 32'hFFFF_FFFE, 1'b1, 1'b0, 1'b0, "3m5");
    op(32'h8000_0000, 32'h0000_0001, 32'h7FFF_FFFF, 1'b0, 1'b1, 1'b0, "ovf");
    op(32'h1234_5678, 32'h1234_5678, 32'h0000_0000, 1'b0, 1'b0, 1'b1, "eq");
    // second request during RUN must be ignored, and operand changes have no effect
    @(negedge clk);
    bus.A = 32'd10;
    bus.B = 32'd4;
    bus.start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.start = 1'b0;
    repeat (4) @(negedge clk);
    bus.A = 32'd1;
    bus.B = 32'd9;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    wait_done(n, bc);
    chk("ignore_latency", n + 6, 33);
    chk("ignore_D", bus.D, 32'd6);
    chk("ignore_Bout", bus.Bout, 0);
    // reset in the middle of RUN aborts with everything cleared
    @(negedge clk);
    bus.A = 32'd20;
    bus.B = 32'd3;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (9) @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    chk("abort_busy", bus.busy, 0);
    chk("abort_done", bus.done, 0);
    chk("abort_D", bus.D, 0);
    chk("abort_flags", {bus.Bout, bus.V, bus.Z}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    pulses = 0;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (bus.done) pulses++;
    end
    chk("abort_no_done", pulses, 0);
    // start held high: DONE ignores it, IDLE re-accepts it
    @(negedge clk);
    bus.A = 32'd7;
    bus.B = 32'd7;
    bus.start = 1'b1;
    wait_done(n, bc);
    t1 = cyc;
    chk("held_first_done", bus.done, 1);
    chk("held_D1", bus.D, 0);
    chk("held_Z1", bus.Z, 1);
    wait_done(n, bc);
    t2 = cyc;
    chk("held_second_done", bus.done, 1);
    chk("held_spacing", t2 - t1, 34);
    chk("held_D2", bus.D, 0);
    chk("held_Z2", bus.Z, 1);
    bus.start = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
